// File: rtl/mapa_pkg.sv
// -----------------------------------------------------------------------------
// mapa_pkg
// Shared definitions for the 7x5 LED matrix path (glyph decoder and scanner):
//   NUM_ROWS / NUM_COLS / MAP_W : matrix geometry and width of the glyph map
//   ROW_W / CNT_W               : row index and phase counter widths
//   scan_state_e                : scan FSM states (IDLE / BLANK / DRIVE)
//   row_slice()                 : column bits of one row out of a 35-bit map
//   row_select()                : active-low row pin vector for one row index
// -----------------------------------------------------------------------------
package mapa_pkg;

    localparam int NUM_ROWS = 7;
    localparam int NUM_COLS = 5;
    localparam int MAP_W    = NUM_ROWS * NUM_COLS;
    localparam int ROW_W    = 3;
    // Wide enough for 2**16 - 1 dwell cycles and up to 255 blank cycles.
    localparam int CNT_W    = 16;

    localparam logic [ROW_W-1:0] LAST_ROW = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    // Columns of row r live at map bits r*5 .. r*5+4; an out-of-range row
    // index yields an all-off row rather than garbage.
    function automatic logic [NUM_COLS-1:0] row_slice(
        input logic [MAP_W-1:0] map,
        input logic [ROW_W-1:0] row
    );
        logic [NUM_COLS-1:0] s;
        case (row)
            3'd0:    s = map[4:0];
            3'd1:    s = map[9:5];
            3'd2:    s = map[14:10];
            3'd3:    s = map[19:15];
            3'd4:    s = map[24:20];
            3'd5:    s = map[29:25];
            3'd6:    s = map[34:30];
            default: s = {NUM_COLS{1'b0}};
        endcase
        return s;
    endfunction

    // Exactly one pin low for a legal row; an illegal index keeps all rows off.
    function automatic logic [NUM_ROWS-1:0] row_select(
        input logic [ROW_W-1:0] row
    );
        logic [NUM_ROWS-1:0] s;
        case (row)
            3'd0:    s = 7'b111_1110;
            3'd1:    s = 7'b111_1101;
            3'd2:    s = 7'b111_1011;
            3'd3:    s = 7'b111_0111;
            3'd4:    s = 7'b110_1111;
            3'd5:    s = 7'b101_1111;
            3'd6:    s = 7'b011_1111;
            default: s = 7'b111_1111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Phase counter for the matrix scanner. Counts cycles since the current
// BLANK or DRIVE phase began; restart=1 zeroes it for the next cycle.
//   clk, rst_n   : clock, asynchronous active-low reset
//   restart      : 1 = next cycle is phase cycle 0
//   cnt          : cycles elapsed in the current phase (dwell_cnt in DRIVE)
//   blank_done   : cnt is the last BLANK cycle (BLANK_CYC - 1)
//   dwell_done   : cnt is the last DRIVE cycle (2**DWELL_LOG2 - 1)
// All outputs are registered: the flags are computed from the next count.
// -----------------------------------------------------------------------------
module scan_timer
    import mapa_pkg::*;
#(
    parameter int DWELL_LOG2 = 8,
    parameter int BLANK_CYC  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    output logic [CNT_W-1:0] cnt,
    output logic             blank_done,
    output logic             dwell_done
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'((2 ** DWELL_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             blank_done_r;
    logic             dwell_done_r;

    // Next count: restart to zero, otherwise count up, saturating so a stuck
    // phase can never wrap back into a terminal value.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (restart) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and terminal-count flags, all decoded from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= {CNT_W{1'b0}};
            blank_done_r <= (BLANK_LAST == {CNT_W{1'b0}});
            dwell_done_r <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            blank_done_r <= (cnt_nxt_s == BLANK_LAST);
            dwell_done_r <= (cnt_nxt_s == DWELL_LAST);
        end
    end

    assign cnt        = cnt_r;
    assign blank_done = blank_done_r;
    assign dwell_done = dwell_done_r;

endmodule

// File: rtl/matrix_scan.sv
// -----------------------------------------------------------------------------
// matrix_scan
// Row-multiplexed driver for the 7x5 LED dot matrix. Latches the glyph map
// once per frame, then scans rows 0..6, each preceded by an all-off gap.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : 1 = scan, 0 = dark and restart from row 0
//   pattern      : 35-bit map, bit r*5+c = row r, column c
//   row_n        : active-low row select (at most one bit low)
//   col          : active-high column drive for the selected row
//   frame_start  : one-cycle pulse in the first BLANK cycle of row 0
//   duty         : brightness 0..15 (only with MATRIX_DIM_EN)
// Build option: define MATRIX_DIM_EN to add the duty port and PWM dimming
// of the columns within each row's DRIVE time.
// Row period = BLANK_CYC + 2**DWELL_LOG2 cycles; frame = 7 row periods.
// -----------------------------------------------------------------------------
module matrix_scan
    import mapa_pkg::*;
#(
    parameter int DWELL_LOG2 = 8,
    parameter int BLANK_CYC  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [MAP_W-1:0]    pattern,
    output logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col,
`ifdef MATRIX_DIM_EN
    output logic                frame_start,
    input  logic [3:0]          duty
`else
    output logic                frame_start
`endif
);

    localparam logic [NUM_ROWS-1:0] ROWS_OFF = 7'h7F;
    localparam logic [NUM_COLS-1:0] COLS_OFF = 5'h00;

    scan_state_e         state_r;
    logic [ROW_W-1:0]    row_r;
    logic [MAP_W-1:0]    latch_r;
    logic [NUM_ROWS-1:0] row_n_r;
    logic [NUM_COLS-1:0] col_r;
    logic                frame_start_r;

    logic [CNT_W-1:0]    dwell_cnt_s;
    logic [CNT_W-1:0]    dwell_nxt_s;
    logic [3:0]          dim_idx_s;
    logic [3:0]          duty_s;
    logic                dim_on_s;
    logic                blank_done_s;
    logic                dwell_done_s;
    logic                restart_s;

    scan_timer #(
        .DWELL_LOG2 (DWELL_LOG2),
        .BLANK_CYC  (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart_s),
        .cnt        (dwell_cnt_s),
        .blank_done (blank_done_s),
        .dwell_done (dwell_done_s)
    );

    // Phase counter restarts whenever a phase ends or the scanner is idle.
    always_comb begin
        restart_s = 1'b1;
        if (!en) begin
            restart_s = 1'b1;
        end else begin
            case (state_r)
                IDLE:    restart_s = 1'b1;
                BLANK:   restart_s = blank_done_s;
                DRIVE:   restart_s = dwell_done_s;
                default: restart_s = 1'b1;
            endcase
        end
    end

    // Dimming gate for the next DRIVE cycle. Without the dimming build the
    // duty is pinned to full so the columns stay on for the whole dwell.
    always_comb begin
`ifdef MATRIX_DIM_EN
        duty_s = duty;
`else
        duty_s = 4'hF;
`endif
        dwell_nxt_s = dwell_cnt_s + CNT_W'(1);
        // Top four bits of the dwell count: 16 equal slices of the on-time.
        dim_idx_s   = 4'(dwell_nxt_s >> (DWELL_LOG2 - 4));
        dim_on_s    = (dim_idx_s <= duty_s);
    end

    // Scan FSM with registered pin outputs: each transition also sets the
    // pin values for the cycle it enters, so pins and state stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            row_r         <= 3'd0;
            latch_r       <= {MAP_W{1'b0}};
            row_n_r       <= ROWS_OFF;
            col_r         <= COLS_OFF;
            frame_start_r <= 1'b0;
        end else if (!en) begin
            state_r       <= IDLE;
            row_r         <= 3'd0;
            row_n_r       <= ROWS_OFF;
            col_r         <= COLS_OFF;
            frame_start_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r       <= BLANK;
                    row_r         <= 3'd0;
                    latch_r       <= pattern;
                    row_n_r       <= ROWS_OFF;
                    col_r         <= COLS_OFF;
                    frame_start_r <= 1'b1;
                end
                BLANK: begin
                    frame_start_r <= 1'b0;
                    if (blank_done_s) begin
                        // First dwell slice is always lit (index 0 <= any duty).
                        state_r <= DRIVE;
                        row_n_r <= row_select(row_r);
                        col_r   <= row_slice(latch_r, row_r);
                    end else begin
                        row_n_r <= ROWS_OFF;
                        col_r   <= COLS_OFF;
                    end
                end
                DRIVE: begin
                    if (dwell_done_s) begin
                        // Rows go dark together with the columns: no ghosting.
                        state_r <= BLANK;
                        row_n_r <= ROWS_OFF;
                        col_r   <= COLS_OFF;
                        if (row_r == LAST_ROW) begin
                            row_r         <= 3'd0;
                            latch_r       <= pattern;
                            frame_start_r <= 1'b1;
                        end else begin
                            row_r         <= row_r + 3'd1;
                            frame_start_r <= 1'b0;
                        end
                    end else begin
                        frame_start_r <= 1'b0;
                        row_n_r       <= row_select(row_r);
                        col_r         <= dim_on_s ? row_slice(latch_r, row_r) : COLS_OFF;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    row_r         <= 3'd0;
                    row_n_r       <= ROWS_OFF;
                    col_r         <= COLS_OFF;
                    frame_start_r <= 1'b0;
                end
            endcase
        end
    end

    assign row_n       = row_n_r;
    assign col         = col_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_matrix_scan.sv
// -----------------------------------------------------------------------------
// tb_matrix_scan
// Self-checking bench for matrix_scan (DWELL_LOG2=4, BLANK_CYC=2: row period
// 18, frame 126). A frame-position model predicts every output cycle.
// -----------------------------------------------------------------------------
module tb_matrix_scan;

    localparam int DWELL_LOG2 = 4;
    localparam int BLANK_CYC  = 2;
    localparam int ROW_P      = BLANK_CYC + (1 << DWELL_LOG2);
    localparam int FRAME_P    = 7 * ROW_P;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [34:0] pattern;
    logic [6:0]  row_n;
    logic [4:0]  col;
    logic        frame_start;
    logic [3:0]  duty_v;

    int checks;
    int errors;
    int cyc;

    // Model state: cycles since the current frame sequence began (-1 = idle).
    int          t_m;
    logic [34:0] latch_m;
    logic [6:0]  e_rn;
    logic [4:0]  e_col;
    logic        e_fs;

    matrix_scan #(
        .DWELL_LOG2 (DWELL_LOG2),
        .BLANK_CYC  (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pattern     (pattern),
        .row_n       (row_n),
        .col         (col),
`ifdef MATRIX_DIM_EN
        .frame_start (frame_start),
        .duty        (duty_v)
`else
        .frame_start (frame_start)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: advance the model on the edge, compare at the falling edge.
    task automatic tick();
        int f, r, p;
        int duty_eff;
        logic [34:0] sh;
        @(posedge clk);
`ifdef MATRIX_DIM_EN
        duty_eff = int'(duty_v);
`else
        duty_eff = 15;
`endif
        if (!en) begin
            t_m = -1;
        end else begin
            t_m = t_m + 1;
            if (t_m % FRAME_P == 0) latch_m = pattern;
        end
        if (t_m < 0) begin
            e_rn = 7'h7F; e_col = 5'h00; e_fs = 1'b0;
        end else begin
            f = t_m % FRAME_P;
            r = f / ROW_P;
            p = f % ROW_P;
            e_fs = (f == 0);
            if (p < BLANK_CYC) begin
                e_rn = 7'h7F; e_col = 5'h00;
            end else begin
                e_rn  = 7'h7F & ~(7'h01 << r);
                sh    = latch_m >> (r * 5);
                e_col = sh[4:0];
                if (((p - BLANK_CYC) >> (DWELL_LOG2 - 4)) > duty_eff) e_col = 5'h00;
            end
        end
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        t_m = -1; latch_m = 35'h0;
        #1;
        checks++;
        if (row_n !== 7'h7F || col !== 5'h00 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_clk got row_n=%h col=%h fs=%b exp 7f 00 0", row_n, col, frame_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (row_n !== 7'h7F || col !== 5'h00 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_dark got row_n=%h col=%h fs=%b exp 7f 00 0", row_n, col, frame_start);
        end
    endtask

    task automatic test_first_frame();
        pattern = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (row_n !== e_rn || col !== e_col || frame_start !== e_fs) begin
                errors++;
                $display("FAIL first_frame t=%0d got %h/%h/%b exp %h/%h/%b", t_m, row_n, col, frame_start, e_rn, e_col, e_fs);
            end
            if (i == 2) begin
                checks++;
                if (row_n !== 7'h7E || col !== latch_m[4:0]) begin
                    errors++;
                    $display("FAIL row0_start got %h/%h exp 7e/%h", row_n, col, latch_m[4:0]);
                end
            end
        end
    endtask

    task automatic test_row_select();
        en = 1'b0; tick();
        pattern = 35'h1F << 15;
        en = 1'b1;
        for (int i = 0; i < FRAME_P + 4; i++) begin
            tick();
            checks++;
            if ((row_n == 7'b1110111) ? (col !== 5'h1F) : (col !== 5'h00)) begin
                errors++;
                $display("FAIL row3_only t=%0d got row_n=%h col=%h", t_m, row_n, col);
            end
            checks++;
            if (row_n !== e_rn || col !== e_col || frame_start !== e_fs) begin
                errors++;
                $display("FAIL row_select t=%0d got %h/%h/%b exp %h/%h/%b", t_m, row_n, col, frame_start, e_rn, e_col, e_fs);
            end
        end
    endtask

    task automatic test_midframe_change();
        logic [34:0] old_p;
        logic [34:0] new_p;
        en = 1'b0; tick();
        old_p = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
        new_p = ~old_p & 35'h7_FFFF_FFFF;
        pattern = old_p;
        en = 1'b1;
        for (int i = 0; i < FRAME_P + 3 * ROW_P; i++) begin
            tick();
            if (t_m == 2 * ROW_P + 5) pattern = new_p;
            if (t_m == 5 * ROW_P + 3) begin
                checks++;
                if (col !== old_p[29:25]) begin
                    errors++;
                    $display("FAIL old_map_row5 got %h exp %h", col, old_p[29:25]);
                end
            end
            if (t_m == FRAME_P + BLANK_CYC) begin
                checks++;
                if (col !== new_p[4:0]) begin
                    errors++;
                    $display("FAIL new_map_row0 got %h exp %h", col, new_p[4:0]);
                end
            end
            checks++;
            if (row_n !== e_rn || col !== e_col || frame_start !== e_fs) begin
                errors++;
                $display("FAIL midframe t=%0d got %h/%h/%b exp %h/%h/%b", t_m, row_n, col, frame_start, e_rn, e_col, e_fs);
            end
        end
    endtask

    task automatic test_frames();
        int last_fs;
        int fs_seen;
        last_fs = -1;
        fs_seen = 0;
        for (int i = 0; i < 3 * FRAME_P + 2; i++) begin
            if ($urandom_range(0, 19) == 0) pattern = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
            tick();
            if (frame_start === 1'b1) begin
                fs_seen++;
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != FRAME_P) begin
                        errors++;
                        $display("FAIL fs_period got %0d exp %0d", cyc - last_fs, FRAME_P);
                    end
                end
                last_fs = cyc;
            end
            checks++;
            if ($countones(~row_n) > 1) begin
                errors++;
                $display("FAIL one_row_low got row_n=%h exp at most one zero", row_n);
            end
            checks++;
            if (row_n !== e_rn || col !== e_col || frame_start !== e_fs) begin
                errors++;
                $display("FAIL frames t=%0d got %h/%h/%b exp %h/%h/%b", t_m, row_n, col, frame_start, e_rn, e_col, e_fs);
            end
        end
        checks++;
        if (fs_seen < 3) begin
            errors++;
            $display("FAIL fs_count got %0d exp >= 3", fs_seen);
        end
    endtask

    task automatic test_disable();
        // Walk into the middle of row 4 DRIVE of the running scan.
        while (t_m % FRAME_P != 4 * ROW_P + BLANK_CYC + 6) tick();
        en = 1'b0;
        tick();
        checks++;
        if (row_n !== 7'h7F || col !== 5'h00 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL disable_dark got %h/%h/%b exp 7f/00/0", row_n, col, frame_start);
        end
        repeat (3) tick();
        pattern = {$urandom, $urandom} & 35'h7_FFFF_FFFF;
        en = 1'b1;
        for (int i = 0; i < FRAME_P; i++) begin
            tick();
            checks++;
            if (row_n !== e_rn || col !== e_col || frame_start !== e_fs) begin
                errors++;
                $display("FAIL reenable t=%0d got %h/%h/%b exp %h/%h/%b", t_m, row_n, col, frame_start, e_rn, e_col, e_fs);
            end
        end
    endtask

    task automatic test_async_reset_mid();
        while (t_m % ROW_P != BLANK_CYC + 3) tick();
        #2 rst_n = 1'b0;
        t_m = -1; latch_m = 35'h0;
        #1;
        checks++;
        if (row_n !== 7'h7F || col !== 5'h00 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %h/%h/%b exp 7f/00/0", row_n, col, frame_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (row_n !== e_rn || col !== e_col || frame_start !== e_fs) begin
                errors++;
                $display("FAIL after_reset t=%0d got %h/%h/%b exp %h/%h/%b", t_m, row_n, col, frame_start, e_rn, e_col, e_fs);
            end
        end
    endtask

`ifdef MATRIX_DIM_EN
    task automatic test_dim();
        int lit;
        logic [3:0] duties [2];
        duties[0] = 4'd3;
        duties[1] = 4'd15;
        for (int d = 0; d < 2; d++) begin
            en = 1'b0; tick();
            pattern = 35'h7_FFFF_FFFF;
            duty_v = duties[d];
            en = 1'b1;
            lit = 0;
            for (int i = 0; i < ROW_P; i++) begin
                tick();
                if (col !== 5'h00) lit++;
            end
            checks++;
            if (lit != int'(duties[d]) + 1) begin
                errors++;
                $display("FAIL dim_lit duty=%0d got %0d exp %0d", duties[d], lit, int'(duties[d]) + 1);
            end
        end
        for (int i = 0; i < FRAME_P; i++) begin
            duty_v = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if (row_n !== e_rn || col !== e_col || frame_start !== e_fs) begin
                errors++;
                $display("FAIL dim_rand t=%0d got %h/%h/%b exp %h/%h/%b", t_m, row_n, col, frame_start, e_rn, e_col, e_fs);
            end
        end
        duty_v = 4'd15;
    endtask
`endif

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rst_n   = 1'b1;
        en      = 1'b0;
        pattern = 35'h0;
        duty_v  = 4'd15;
        t_m     = -1;
        latch_m = 35'h0;
        test_reset();
        test_first_frame();
        test_row_select();
        test_midframe_change();
        test_frames();
        test_disable();
        test_async_reset_mid();
`ifdef MATRIX_DIM_EN
        test_dim();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
